vec_addsub_fifo: RTL and testbench

Parametrised lane-wise signed add/subtract engine with a built-in result FIFO, used wherever the ray pipeline forms vector differences or sums (edge vectors, origin offsets, hit-point translation). It pops operand pairs from an upstream first-word-fall-through FIFO and applies a per-transaction opcode. It can clamp on overflow. Unlike the earlier two-state subtractor, it sustains one transaction per clock.

---
 rtl/vec_addsub_fifo.sv | 126 ++++++++++++
 tb/tb_vec_addsub_fifo.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_addsub_fifo.sv
// Lane-wise signed add/subtract engine with a show-ahead result FIFO.
//
// Operand pairs are popped from an upstream first-word-fall-through FIFO. Each
// transaction passes through one stage register and is then written into a
// circular result buffer. The design sustains one transaction per clock.
//
// Ports:
//   clock, reset  clock and asynchronous active-high reset
//   x, y          per-lane signed operands, valid while in_empty=0
//   op            0: out = x - y, 1: out = x + y (travels with x/y)
//   in_empty      upstream FIFO empty
//   in_rd_en      pop upstream; operands are consumed at this edge
//   out, ovf      head-of-FIFO result and per-lane overflow flags
//   out_empty     result FIFO empty
//   out_rd_en     pop head entry (ignored while empty)
//   count         number of entries stored in the result FIFO
module vec_addsub_fifo #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned LANES    = 3,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned SATURATE = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [LANES-1:0][WIDTH-1:0]      x,
  input  logic [LANES-1:0][WIDTH-1:0]      y,
  input  logic                             op,
  input  logic                             in_empty,
  output logic                             in_rd_en,
  output logic [LANES-1:0][WIDTH-1:0]      out,
  output logic [LANES-1:0]                 ovf,
  output logic                             out_empty,
  input  logic                             out_rd_en,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic                        stage_valid_q, stage_valid_d;
  logic [LANES-1:0][WIDTH-1:0] stage_data_q, stage_data_d;
  logic [LANES-1:0]            stage_ovf_q, stage_ovf_d;
  logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]             count_q, count_d;
  logic [LANES-1:0][WIDTH-1:0] mem_q [DEPTH];
  logic [LANES-1:0]            ovf_mem_q [DEPTH];

  logic [LANES-1:0][WIDTH-1:0] res;
  logic [LANES-1:0]            res_ovf;
  logic [WIDTH:0]              sx, sy, sum;
  logic [CntW:0]               occupancy;
  logic                        wr_en, pop;

  // Credit counts the in-flight stage entry; a same-cycle pop earns nothing.
  assign occupancy = {1'b0, count_q} + (CntW+1)'(stage_valid_q);
  assign in_rd_en  = !reset && !in_empty && (occupancy < (CntW+1)'(DEPTH));

  // Arithmetic in WIDTH+1 bits so negating the minimum value cannot overflow.
  always_comb begin
    res     = '0;
    res_ovf = '0;
    sx      = '0;
    sy      = '0;
    sum     = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      sx         = {x[i][WIDTH-1], x[i]};
      sy         = {y[i][WIDTH-1], y[i]};
      sum        = op ? (sx + sy) : (sx - sy);
      res_ovf[i] = sum[WIDTH] ^ sum[WIDTH-1];
      res[i]     = sum[WIDTH-1:0];
      if ((SATURATE != 0) && res_ovf[i]) begin
        res[i] = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
    end
  end

  assign wr_en     = stage_valid_q;
  assign out_empty = (count_q == '0);
  assign pop       = out_rd_en && !out_empty;

  always_comb begin
    stage_valid_d = in_rd_en;
    stage_data_d  = in_rd_en ? res : stage_data_q;
    stage_ovf_d   = in_rd_en ? res_ovf : stage_ovf_q;
    wr_ptr_d      = wr_ptr_q + PtrW'(wr_en);
    rd_ptr_d      = rd_ptr_q + PtrW'(pop);
    count_d       = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      stage_ovf_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_data_q  <= stage_data_d;
      stage_ovf_q   <= stage_ovf_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q]     <= stage_data_q;
      ovf_mem_q[wr_ptr_q] <= stage_ovf_q;
    end
  end

  assign out   = out_empty ? '0 : mem_q[rd_ptr_q];
  assign ovf   = out_empty ? '0 : ovf_mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: tb/tb_vec_addsub_fifo.sv
// Directed bench for vec_addsub_fifo. A wrapping instance and a saturating
// instance share all inputs; an upstream FWFT FIFO is modelled by a queue.
module tb_vec_addsub_fifo;

  typedef logic [2:0][31:0] vec_t;
  typedef struct packed {
    vec_t x;
    vec_t y;
    logic op;
  } txn_t;

  logic       clock = 1'b0;
  logic       reset;
  vec_t       x, y;
  logic       op, in_empty, out_rd_en;
  logic       in_rd_en, in_rd_en_s;
  vec_t       out_w, out_s;
  logic [2:0] ovf_w, ovf_s;
  logic       out_empty, out_empty_s;
  logic [4:0] count, count_s;

  txn_t q[$];
  vec_t exp_q[$];
  int   vectors = 0;
  int   misc = 0;

  always #5 clock = ~clock;

  vec_addsub_fifo #(.WIDTH(32), .LANES(3), .DEPTH(16), .SATURATE(0)) dut (
    .clock(clock), .reset(reset), .x(x), .y(y), .op(op), .in_empty(in_empty),
    .in_rd_en(in_rd_en), .out(out_w), .ovf(ovf_w), .out_empty(out_empty),
    .out_rd_en(out_rd_en), .count(count)
  );

  vec_addsub_fifo #(.WIDTH(32), .LANES(3), .DEPTH(16), .SATURATE(1)) dut_sat (
    .clock(clock), .reset(reset), .x(x), .y(y), .op(op), .in_empty(in_empty),
    .in_rd_en(in_rd_en_s), .out(out_s), .ovf(ovf_s), .out_empty(out_empty_s),
    .out_rd_en(out_rd_en), .count(count_s)
  );

  function automatic vec_t v3(input int a, input int b, input int c);
    vec_t v;
    v[0] = a;
    v[1] = b;
    v[2] = c;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    vectors++;
    assert (obs === expv) else begin
      misc++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input vec_t a, input vec_t b, input logic o);
    txn_t t;
    t.x = a;
    t.y = b;
    t.op = o;
    q.push_back(t);
  endtask

  // Transaction k with closed-form expected result.
  task automatic gen(input int k, input logic o);
    push(v3(k, 1000 - k, -k), v3(3, k, 5), o);
    if (o) exp_q.push_back(v3(k + 3, 1000, 5 - k));
    else   exp_q.push_back(v3(k - 3, 1000 - 2 * k, -k - 5));
  endtask

  // Present the upstream head, then let combinational outputs settle.
  task automatic load();
    in_empty = (q.size() == 0);
    if (q.size() != 0) begin
      x  = q[0].x;
      y  = q[0].y;
      op = q[0].op;
    end
    #1;
  endtask

  // One clock: the upstream pops if in_rd_en was high before the edge.
  task automatic cycle();
    logic rd;
    rd = in_rd_en;
    @(posedge clock);
    if (rd && q.size() != 0) q.delete(0);
    #1 load();
  endtask

  // Pop results every cycle until the expected queue drains.
  task automatic drain(input string tag, input int budget, output int n, output int first);
    n = 0;
    first = -1;
    while (exp_q.size() != 0 && n < budget) begin
      chk({tag, "_count_le2"}, 96'(count <= 5'd2), 96'd1);
      if (!out_empty) begin
        if (first < 0) first = n;
        chk({tag, "_data"}, out_w, exp_q[0]);
        chk({tag, "_ovf"}, 96'(ovf_w), 96'd0);
        exp_q.delete(0);
      end
      cycle();
      n++;
    end
    chk({tag, "_all_done"}, 96'(exp_q.size()), 96'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first;
    reset = 1'b1;
    out_rd_en = 1'b0;
    x = '0;
    y = '0;
    op = 1'b0;
    in_empty = 1'b1;
    @(posedge clock);
    #1 load();

    // Reset state and credit forced low while reset is high
    chk("rst_out_empty", 96'(out_empty), 96'd1);
    chk("rst_count", 96'(count), 96'd0);
    chk("rst_rd_en", 96'(in_rd_en), 96'd0);
    push(v3(1, 1, 1), v3(0, 0, 0), 1'b1);
    load();
    chk("rst_rd_en_pending", 96'(in_rd_en), 96'd0);
    q.delete(0);
    load();
    cycle();
    reset = 1'b0;
    #1;
    cycle();
    chk("idle_out_empty", 96'(out_empty), 96'd1);
    chk("idle_count", 96'(count), 96'd0);
    chk("idle_rd_en", 96'(in_rd_en), 96'd0);
    chk("idle_out", out_w, 96'd0);

    // Subtract, two-edge latency
    push(v3(5, -3, 10), v3(2, 4, -6), 1'b0);
    load();
    chk("sub_rd_en", 96'(in_rd_en), 96'd1);
    cycle();
    chk("sub_e0_empty", 96'(out_empty), 96'd1);
    cycle();
    chk("sub_out", out_w, v3(3, -7, 16));
    chk("sub_ovf", 96'(ovf_w), 96'd0);
    chk("sub_count", 96'(count), 96'd1);
    chk("sub_out_empty", 96'(out_empty), 96'd0);
    out_rd_en = 1'b1;
    cycle();
    chk("sub_pop_empty", 96'(out_empty), 96'd1);
    chk("sub_pop_count", 96'(count), 96'd0);
    cycle();
    chk("pop_while_empty_count", 96'(count), 96'd0);
    chk("pop_while_empty_flag", 96'(out_empty), 96'd1);
    out_rd_en = 1'b0;

    // Overflow: add then subtract, wrap vs saturate
    push(v3(32'h7FFF_FFFF, 1, -1), v3(1, 2, -1), 1'b1);
    push(v3(32'h8000_0000, 0, 32'h8000_0000), v3(1, 32'h8000_0000, 0), 1'b0);
    load();
    chk("sat_rd_en", 96'(in_rd_en_s), 96'd1);
    repeat (3) cycle();
    chk("ovf_count", 96'(count), 96'd2);
    chk("ovf_count_sat", 96'(count_s), 96'd2);
    chk("add_ovf_wrap", out_w, v3(32'h8000_0000, 3, -2));
    chk("add_ovf_flags", 96'(ovf_w), 96'b001);
    chk("add_ovf_sat", out_s, v3(32'h7FFF_FFFF, 3, -2));
    chk("add_ovf_flags_sat", 96'(ovf_s), 96'b001);
    out_rd_en = 1'b1;
    cycle();
    chk("sub_ovf_wrap", out_w, v3(32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000));
    chk("sub_ovf_flags", 96'(ovf_w), 96'b011);
    chk("sub_ovf_sat", out_s, v3(32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000));
    chk("sub_ovf_flags_sat", 96'(ovf_s), 96'b011);
    cycle();
    out_rd_en = 1'b0;
    chk("ovf_drained", 96'(out_empty_s), 96'd1);

    // Backpressure: 20 offered, no pops
    for (int k = 1; k <= 20; k++) gen(k, 1'b1);
    load();
    repeat (20) cycle();
    chk("bp_count_full", 96'(count), 96'd16);
    chk("bp_rd_en_low", 96'(in_rd_en), 96'd0);
    chk("bp_accepted", 96'(q.size()), 96'd4);
    out_rd_en = 1'b1;
    chk("bp_head", out_w, exp_q[0]);
    exp_q.delete(0);
    cycle();
    out_rd_en = 1'b0;
    chk("bp_after_pop_count", 96'(count), 96'd15);
    chk("bp_rd_en_reassert", 96'(in_rd_en), 96'd1);
    cycle();
    chk("bp_17th_accepted", 96'(q.size()), 96'd3);
    cycle();
    chk("bp_refull_count", 96'(count), 96'd16);
    chk("bp_refull_rd_en", 96'(in_rd_en), 96'd0);
    out_rd_en = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      if (!out_empty) begin
        chk("bp_drain", out_w, exp_q[0]);
        exp_q.delete(0);
      end
      cycle();
      n++;
    end
    chk("bp_drain_done", 96'(exp_q.size()), 96'd0);
    chk("bp_drain_empty", 96'(out_empty), 96'd1);

    // Continuous stream: one result per cycle, pointers wrap
    for (int k = 100; k < 140; k++) gen(k, k[0]);
    load();
    drain("stream", 200, n, first);
    chk("stream_first_latency", 96'(first), 96'd2);
    chk("stream_cycles", 96'(n), 96'd42);
    chk("stream_end_empty", 96'(out_empty), 96'd1);

    // Reset with count=5 and stage_valid=1
    out_rd_en = 1'b0;
    for (int k = 200; k < 210; k++) gen(k, 1'b0);
    load();
    repeat (6) cycle();
    chk("mid_count", 96'(count), 96'd5);
    reset = 1'b1;
    #1;
    chk("mid_rst_empty", 96'(out_empty), 96'd1);
    chk("mid_rst_count", 96'(count), 96'd0);
    chk("mid_rst_rd_en", 96'(in_rd_en), 96'd0);
    chk("mid_rst_out", out_w, 96'd0);
    repeat (6) exp_q.delete(0);
    cycle();
    chk("mid_upstream_kept", 96'(q.size()), 96'd4);
    reset = 1'b0;
    #1;
    out_rd_en = 1'b1;
    drain("post_rst", 50, n, first);
    chk("post_rst_first", 96'(first), 96'd2);
    chk("post_rst_empty", 96'(out_empty), 96'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
